// File: rtl/alu_sequencer.sv
// Sequenced ALU: single-cycle arithmetic/logic ops plus an N-cycle restoring divider for DIV/MOD.
// Optional ALU_SEQ_PERF_COUNT_EN adds a saturating 16-bit op_count output.
module alu_sequencer #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         zero,
    output logic         carry,
    output logic         negative,
    output logic         overflow,
    output logic         dbz
`ifdef ALU_SEQ_PERF_COUNT_EN
    ,
    output logic [15:0]  op_count
`endif
);

    localparam int unsigned CNT_W  = $clog2(N + 1);
    localparam int unsigned PROD_W = 2 * N;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       result_nxt;
    logic               busy_nxt, done_nxt;
    logic               zero_nxt, carry_nxt, negative_nxt, overflow_nxt, dbz_nxt;

    // divider working registers: quotient shifts in from the dividend
    logic [N-1:0]       quo, quo_nxt;
    logic [N-1:0]       rem, rem_nxt;
    logic [N-1:0]       divisor, divisor_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               is_mod, is_mod_nxt;

    logic [N:0]         sum;
    logic [PROD_W-1:0]  prod;
    logic [N-1:0]       alu_res;
    logic               alu_carry, alu_neg, alu_ovf;

    logic [N:0]         trial;
    logic [N-1:0]       diff;
    logic               step_bit;
    logic [N-1:0]       step_rem;
    logic [N-1:0]       quo_step;
    logic [N-1:0]       div_out;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = PROD_W'(a) * PROD_W'(b);

    // one restoring-division step; diff is only used when trial >= divisor, so it fits N bits
    assign trial    = {rem, quo[N-1]};
    assign step_bit = (trial >= {1'b0, divisor});
    assign diff     = trial[N-1:0] - divisor;
    assign step_rem = step_bit ? diff : trial[N-1:0];
    assign quo_step = {quo[N-2:0], step_bit};
    assign div_out  = is_mod ? step_rem : quo_step;

    // single-cycle operation results, computed directly from the inputs at the accepting edge
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_neg   = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum[N-1:0];
                alu_carry = sum[N];
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_neg = (a < b);
            end
            OP_MUL: begin
                alu_res = prod[N-1:0];
                alu_ovf = |prod[PROD_W-1:N];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        result_nxt   = result;
        zero_nxt     = zero;
        carry_nxt    = carry;
        negative_nxt = negative;
        overflow_nxt = overflow;
        dbz_nxt      = dbz;
        quo_nxt      = quo;
        rem_nxt      = rem;
        divisor_nxt  = divisor;
        cnt_nxt      = cnt;
        is_mod_nxt   = is_mod;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if ((op == OP_DIV) || (op == OP_MOD)) begin
                        if (b == '0) begin
                            state_nxt    = S_DONE;
                            result_nxt   = '0;
                            zero_nxt     = 1'b1;
                            carry_nxt    = 1'b0;
                            negative_nxt = 1'b0;
                            overflow_nxt = 1'b0;
                            dbz_nxt      = 1'b1;
                        end else begin
                            state_nxt   = S_DIV;
                            quo_nxt     = a;
                            rem_nxt     = '0;
                            divisor_nxt = b;
                            cnt_nxt     = '0;
                            is_mod_nxt  = (op == OP_MOD);
                        end
                    end else begin
                        state_nxt    = S_DONE;
                        result_nxt   = alu_res;
                        zero_nxt     = (alu_res == '0);
                        carry_nxt    = alu_carry;
                        negative_nxt = alu_neg;
                        overflow_nxt = alu_ovf;
                        dbz_nxt      = 1'b0;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                quo_nxt = quo_step;
                rem_nxt = step_rem;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(N - 1)) begin
                    state_nxt    = S_DONE;
                    result_nxt   = div_out;
                    zero_nxt     = (div_out == '0);
                    carry_nxt    = 1'b0;
                    negative_nxt = 1'b0;
                    overflow_nxt = 1'b0;
                    dbz_nxt      = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt == S_DIV);
        done_nxt = (state_nxt == S_DONE);
    end

    // state, outputs and divider registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
            dbz      <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            cnt      <= '0;
            is_mod   <= 1'b0;
        end else begin
            state    <= state_nxt;
            result   <= result_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            zero     <= zero_nxt;
            carry    <= carry_nxt;
            negative <= negative_nxt;
            overflow <= overflow_nxt;
            dbz      <= dbz_nxt;
            quo      <= quo_nxt;
            rem      <= rem_nxt;
            divisor  <= divisor_nxt;
            cnt      <= cnt_nxt;
            is_mod   <= is_mod_nxt;
        end
    end

`ifdef ALU_SEQ_PERF_COUNT_EN
    // completion counter, advances with each done pulse and saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count <= '0;
        end else if ((state_nxt == S_DONE) && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer (N=4): vector table plus divide/reset corner sequences.
module tb_alu_sequencer;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;
    localparam int NVEC = 17;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       z;
        logic       c;
        logic       n;
        logic       v;
        logic       d;
        int         lat;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] result;
    logic       busy, done, zero, carry, negative, overflow, dbz;
`ifdef ALU_SEQ_PERF_COUNT_EN
    logic [15:0] op_count;
`endif

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];
    vec_t tbl[NVEC];

    alu_sequencer #(.N(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .zero     (zero),
        .carry    (carry),
        .negative (negative),
        .overflow (overflow),
        .dbz      (dbz)
`ifdef ALU_SEQ_PERF_COUNT_EN
        ,
        .op_count (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                                input logic [3:0] r, input logic z, input logic c, input logic n,
                                input logic v, input logic d, input int lat);
        vec_t t;
        t.op = o; t.a = x; t.b = y; t.res = r;
        t.z = z; t.c = c; t.n = n; t.v = v; t.d = d; t.lat = lat;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drive a request and record its expected outcome
    task automatic issue(input vec_t e, input bit wait_edge);
        if (wait_edge) @(negedge clk);
        start = 1'b1;
        op    = e.op;
        a     = e.a;
        b     = e.b;
        sb.push_back(e);
    endtask

    // drop start after the accepting edge and scramble operands to prove they were latched
    task automatic finish_issue();
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = 4'($urandom);
        b     = 4'($urandom);
    endtask

    // wait (bounded) for done, then pop the scoreboard and compare
    task automatic collect(input string name, input int k0);
        vec_t e;
        int   k;
        int   busy_bad;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty", name);
            $fatal(1, "scoreboard underflow");
        end
        e = sb[0];
        k = k0;
        busy_bad = 0;
        while ((done !== 1'b1) && (k < 20)) begin
            if (busy !== ((e.lat > 1) && (k < e.lat))) busy_bad++;
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        check({name, " latency"}, 32'(k), 32'(e.lat));
        check({name, " busy"}, 32'(busy_bad), 32'd0);
        check({name, " outputs"},
              {22'd0, result, zero, carry, negative, overflow, dbz, busy},
              {22'd0, e.res, e.z, e.c, e.n, e.v, e.d, 1'b0});
    endtask

    initial begin
        vec_t e;

        tbl[0]  = mk(OP_ADD, 4'd9,  4'd8,  4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        tbl[1]  = mk(OP_ADD, 4'd3,  4'd4,  4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tbl[2]  = mk(OP_ADD, 4'd8,  4'd8,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        tbl[3]  = mk(OP_SUB, 4'd3,  4'd5,  4'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        tbl[4]  = mk(OP_SUB, 4'd5,  4'd5,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tbl[5]  = mk(OP_MUL, 4'd5,  4'd4,  4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        tbl[6]  = mk(OP_MUL, 4'd3,  4'd5,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tbl[7]  = mk(OP_DIV, 4'd13, 4'd3,  4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        tbl[8]  = mk(OP_MOD, 4'd13, 4'd3,  4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        tbl[9]  = mk(OP_DIV, 4'd7,  4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tbl[10] = mk(OP_MOD, 4'd15, 4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tbl[11] = mk(OP_DIV, 4'd2,  4'd7,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        tbl[12] = mk(OP_MOD, 4'd15, 4'd15, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        tbl[13] = mk(OP_DIV, 4'd15, 4'd1,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        tbl[14] = mk(OP_AND, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tbl[15] = mk(OP_OR,  4'd12, 4'd10, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tbl[16] = mk(OP_XOR, 4'd12, 4'd12, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        reset = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {23'd0, result, busy, done, zero, carry, negative, overflow, dbz}, 32'd0);
        reset = 1'b1;

        // table-driven single operations, each followed by a done-pulse/hold check
        for (int i = 0; i < NVEC; i++) begin
            issue(tbl[i], 1'b1);
            finish_issue();
            collect($sformatf("vec%0d", i), 1);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d hold", i), 32'(result), 32'(tbl[i].res));
        end

        // start during divide is ignored; start in the DONE cycle is accepted
        issue(mk(OP_DIV, 4'd13, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5), 1'b1);
        finish_issue();
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        collect("ignored start", 3);
        issue(mk(OP_ADD, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1), 1'b0);
        finish_issue();
        collect("back-to-back", 1);

        // reset in the middle of a divide aborts it immediately
        issue(mk(OP_DIV, 4'd13, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5), 1'b1);
        finish_issue();
        @(negedge clk);
        check("busy before reset", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async reset outputs", {23'd0, result, busy, done, zero, carry, negative, overflow, dbz}, 32'd0);
`ifdef ALU_SEQ_PERF_COUNT_EN
        check("op_count after reset", 32'(op_count), 32'd0);
`endif
        sb.delete();
        @(negedge clk);
        check("held in reset", {30'd0, busy, done}, 32'd0);
        reset = 1'b1;
        e = mk(OP_ADD, 4'd9, 4'd8, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue(e, 1'b0);
        finish_issue();
        collect("first start after reset", 1);
`ifdef ALU_SEQ_PERF_COUNT_EN
        check("op_count after completion", 32'(op_count), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: N, default 4, operand/result width in bits (N >= 2).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request; accepted when block is in IDLE or DONE.
REQ-006 Port: op  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR.
REQ-007 Port: a, b  input  N each  unsigned operands, sampled only on accepted start.
REQ-008 Port: result  output  N  registered result, held until next completion.
REQ-009 Port: busy  output  1  high while in state DIV.
REQ-010 Port: done  output  1  one-cycle pulse marking new valid result/flags.
REQ-011 Port: zero, carry, negative, overflow, dbz  output  1 each  registered status flags.

Function
REQ-012 States SHALL be IDLE, DIV, DONE; IDLE->DONE on accepted non-divide op; IDLE->DIV on accepted DIV/MOD with b!=0; IDLE->DONE on DIV/MOD with b==0; DIV->DONE after N iterations; DONE->IDLE if no start, DONE->(DIV|DONE) on start per same rules.
REQ-013 Operands and opcode SHALL be latched on the accepting edge; later changes to a, b, op SHALL not affect the operation in progress.
REQ-014 Single-cycle ops SHALL complete with done=1 in the cycle immediately after the accepting edge (latency 1).
REQ-015 DIV/MOD SHALL use an internal restoring shift-subtract divider, one quotient bit per cycle, done=1 exactly N+1 cycles after the accepting edge.
REQ-016 ADD: result = (a+b) mod 2^N, carry = carry-out; SUB: result = (a-b) mod 2^N, negative = 1 iff a<b.
REQ-017 MUL: result = low N bits of the 2N-bit product, overflow = 1 iff high N bits non-zero.
REQ-018 DIV: result = quotient; MOD: result = remainder; b==0: result = 0, dbz = 1, latency 1.
REQ-019 AND/OR/XOR: bitwise result; flags not listed for an op SHALL be 0 for that op.
REQ-020 zero SHALL be 1 iff the new result is 0 (including dbz case).
REQ-021 start while busy=1 SHALL be ignored with no effect on state, result or flags.
REQ-022 All outputs SHALL change only on the edge entering DONE, except busy and done which follow state.

Reset
REQ-023 reset low SHALL immediately force state IDLE and result, busy, done, zero, carry, negative, overflow, dbz to 0, aborting any divide in progress.
REQ-024 After reset release, the first start SHALL be accepted on the first rising edge where reset is high.

Configuration
REQ-025 Macro ALU_SEQ_PERF_COUNT_EN, when defined, SHALL add output op_count (16 bits), reset to 0, incremented on every done pulse, saturating at 16'hFFFF.
REQ-026 Without ALU_SEQ_PERF_COUNT_EN the op_count port and counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-027 N=4, ADD a=9 b=8 -> cycle+1: done=1, result=1, carry=1, zero=0, busy never high.
REQ-028 N=4, DIV a=13 b=3 -> busy high cycles 1-4, cycle 5: done=1, result=4; repeat as MOD -> result=1.
REQ-029 N=4, DIV a=7 b=0 -> cycle+1: done=1, dbz=1, result=0, zero=1, busy never high.
REQ-030 N=4, MUL a=5 b=4 -> result=4, overflow=1; SUB a=3 b=5 -> result=14, negative=1.
REQ-031 DIV 13/3 started, start with ADD 1+1 at cycle 2 -> ignored, cycle 5 result=4; back-to-back start in DONE cycle accepted.
REQ-032 reset low at cycle 3 of DIV -> all outputs 0 immediately, IDLE; op_count (if enabled) 0 and increments to 1 after next completion.
